asu_result_buffer: RTL
======================

// Module: asu_result_buffer
// PURPOSE
//  Downstream stage of the 8-bit add/shift unit (ASU). Captures each ASU result
//  {carry,out[7:0]} together with its mode bit into a small FIFO. Presents the
//  results to the consumer over a valid/ready handshake. Keeps a saturating count
//  of add-mode results with carry=1. Decouples the combinational ASU from a
//  consumer that may stall.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, >=2
//  CNT_W  8  width of carry_cnt
// PORTS
//  clk        in   1      single clock; all state changes on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      ASU result valid this cycle
//  in_mode    in   1      ASU mode for this result: 0=add, 1=shift
//  in_carry   in   1      ASU carry output
//  in_out     in   8      ASU out[7:0]
//  in_ready   out  1      buffer can accept an entry (= !full)
//  out_valid  out  1      head entry available (= !empty)
//  out_ready  in   1      consumer accepts head entry
//  out_data   out  9      head entry {carry,out}
//  out_mode   out  1      head entry mode
//  count      out  log2(DEPTH)+1  current occupancy
//  carry_cnt  out  CNT_W  add-mode pushes with carry=1, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): rd/wr pointers=0, count=0, carry_cnt=0; out_valid=0,
//    in_ready=1. out_data and out_mode read 0. FIFO RAM is not cleared.
//  - push = in_valid & in_ready. pop = out_valid & out_ready. Both take effect at posedge.
//  - in_ready and out_valid are decoded from registered count only. There is no
//    combinational path from out_ready to in_ready. When full, a push is refused
//    even if a pop happens in the same cycle.
//  - Latency: an entry pushed at edge N is visible at out_data/out_valid after edge N
//    (first-word fall-through from registered storage, combinational read of head).
//  - Simultaneous push and pop (0<count<DEPTH): count unchanged, both pointers
//    advance. At count=0 only the push happens, because out_valid=0.
//  - Pointers wrap modulo DEPTH. Occupancy is held in the separate count register,
//    so full and empty are never ambiguous.
//  - in_valid while full: data is ignored and not stored. Upstream holds its inputs
//    until in_ready.
//  - out_ready while empty: no effect; pointers are unchanged.
//  - carry_cnt increments on a push with in_mode=0 and in_carry=1. It holds at
//    2^CNT_W-1. Shift-mode pushes never count.
//  - Inputs (in_valid, in_mode, in_carry, in_out) are X-tolerant when in_valid=0.
//  - Reset asserted mid-operation discards all stored entries immediately. The first
//    edge after rst_n rises behaves as from empty.
// CONFIGURATION
//  ASU_SAT_EN defined: an add-mode push with in_carry=1 stores out=8'hFF
//    (saturated). The stored carry stays 1. Shift-mode entries are stored unchanged.
//  ASU_SAT_EN undefined: all entries are stored exactly as received
//    ({in_carry,in_out}).
//  carry_cnt behaviour is identical in both builds.
// TESTING
//  1 Reset: rst_n=0 mid-stream with 3 entries held -> out_valid=0, count=0,
//    carry_cnt=0, in_ready=1 at once.
//  2 Pass-through: push mode0 {1,8'h2A}, out_ready=1 -> next cycle out_data=9'h12A,
//    out_mode=0, pop, count returns to 0.
//  3 Fill/full: 4 pushes with out_ready=0 -> count=4, in_ready=0; 5th push 9'h0FF
//    dropped; drain order equals push order.
//  4 Simultaneous push and pop at count=2 -> count stays 2. At count=4 with
//    out_ready=1 and in_valid=1 -> count=3, push refused.
//  5 Carry count: 3 add pushes with carry=1, 2 shift pushes with carry=1 ->
//    carry_cnt=3. Force 255 counting pushes -> carry_cnt holds 8'hFF.
//  6 ASU_SAT_EN: add push {1,8'h12} -> out_data=9'h1FF. Shift push {1,8'h12} ->
//    9'h112. Without the macro the add push gives 9'h112.

Source files
------------

// File: rtl/asu_result_buffer.sv
// ---------------------------------------------------------------------------
// asu_result_buffer
//
// Result buffer placed behind the 8-bit add/shift unit (ASU). Each ASU result
// {carry, out[7:0]} is captured with its mode bit into a small FIFO and handed
// to the consumer over a valid/ready handshake. A saturating counter tracks
// how many add-mode results with carry=1 were accepted.
//
// Build option:
//   ASU_SAT_EN  - when defined, an add-mode entry with carry=1 is stored with
//                 out forced to 8'hFF (carry kept at 1). Shift-mode entries and
//                 the carry counter are unaffected. Default build stores every
//                 entry exactly as received.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  width of carry_cnt
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   ASU result valid this cycle
//   in_mode    in   ASU mode: 0 = add, 1 = shift
//   in_carry   in   ASU carry output
//   in_out     in   ASU out[7:0]
//   in_ready   out  buffer can accept an entry (not full)
//   out_valid  out  head entry available (not empty)
//   out_ready  in   consumer accepts the head entry
//   out_data   out  head entry {carry, out}, 0 when empty
//   out_mode   out  head entry mode, 0 when empty
//   count      out  current occupancy
//   carry_cnt  out  add-mode accepted entries with carry=1, saturating
// ---------------------------------------------------------------------------
module asu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_mode,
    input  logic                       in_carry,
    input  logic [7:0]                 in_out,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [8:0]                 out_data,
    output logic                       out_mode,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           carry_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic [9:0]    mem [DEPTH];

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [7:0]    stored_out;
    logic [9:0]    wr_entry;
    logic [9:0]    head;
    logic          carry_hit;

    // Flags come from the registered occupancy only, so out_ready never
    // reaches in_ready combinationally; a full buffer refuses a push even
    // when the head is popped in the same cycle.
    assign full      = (occ == CW'(DEPTH));
    assign empty     = (occ == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    assign carry_hit = push & ~in_mode & in_carry;

`ifdef ASU_SAT_EN
    assign stored_out = (~in_mode & in_carry) ? 8'hFF : in_out;
`else
    assign stored_out = in_out;
`endif

    // Entry layout: {mode, carry, out[7:0]}
    assign wr_entry = {in_mode, in_carry, stored_out};

    // Storage is deliberately not reset; empty slots are masked at the output.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt <= '0;
        end else if (carry_hit && (carry_cnt != {CNT_W{1'b1}})) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end

    // First-word fall-through: head is read combinationally from storage.
    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head[8:0] : 9'h000;
    assign out_mode = out_valid & head[9];
    assign count    = occ;

endmodule
